// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle for the multi-cycle ALU execute stage.
// The master drives the request; the slave (alu_exec) returns the registered result.
interface alu_exec_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              err;
  logic              busy;
  logic              done;

  modport master (
    output start, funct, src1, src2, shamt,
    input  result, zero, err, busy, done
  );

  modport slave (
    input  start, funct, src1, src2, shamt,
    output result, zero, err, busy, done
  );
endinterface

// File: rtl/alu_exec.sv
// ALU execute stage: single-edge Addu/Subu/And, bit-serial SLL (one bit per edge),
// and an error completion for unsupported funct codes.
module alu_exec #(
  parameter int unsigned DATA_W = 32
) (
  input logic        clk,
  input logic        rst,
  alu_exec_if.slave  bus
);
  localparam logic [5:0] FN_ADDU = 6'h09;
  localparam logic [5:0] FN_SUBU = 6'h0A;
  localparam logic [5:0] FN_AND  = 6'h11;
  localparam logic [5:0] FN_SLL  = 6'h21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] result, result_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic [4:0]        cnt, cnt_n;
  logic              zero, zero_n;
  logic              err, err_n;
  logic              complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      sreg   <= '0;
      cnt    <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      result <= result_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      zero   <= zero_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    result_n = result;
    sreg_n   = sreg;
    cnt_n    = cnt;
    err_n    = err;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          complete = 1'b1;
          err_n    = 1'b0;
          state_n  = DONE;
          case (bus.funct)
            FN_ADDU: result_n = bus.src1 + bus.src2;
            FN_SUBU: result_n = bus.src1 - bus.src2;
            FN_AND:  result_n = bus.src1 & bus.src2;
            FN_SLL: begin
              if (bus.shamt == 5'd0) begin
                result_n = bus.src2;
              end else begin
                complete = 1'b0;
                sreg_n   = bus.src2;
                cnt_n    = bus.shamt;
                state_n  = SHIFT;
              end
            end
            default: begin
              result_n = '0;
              err_n    = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        sreg_n = sreg << 1;
        cnt_n  = cnt - 5'd1;
        // Final shift lands straight in result, so SLL takes 1+k edges.
        if (cnt == 5'd1) begin
          result_n = sreg << 1;
          err_n    = 1'b0;
          complete = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    zero_n = complete ? (result_n == '0) : zero;
  end

  assign bus.result = result;
  assign bus.zero   = zero;
  assign bus.err    = err;
  assign bus.busy   = (state == SHIFT) || (state == DONE);
  assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: vector table plus hand-written
// sequences for start-during-busy, start held through DONE and mid-shift reset.
module tb_alu_exec;
  logic clk;
  logic rst;

  alu_exec_if #(.DATA_W(32)) bus ();

  alu_exec #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE (called at posedge+1) and wait for done, bounded.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int lat);
    bus.start = 1'b1;
    bus.funct = f;
    bus.src1  = a;
    bus.src2  = b;
    bus.shamt = sh;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.funct = 6'($urandom);
    bus.src1  = $urandom;
    bus.src2  = $urandom;
    bus.shamt = 5'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int npulse;
    logic [31:0] held;

    tests = 0;
    fails = 0;

    vecs[0]  = '{6'h09, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[1]  = '{6'h0A, 32'h0000_0005, 32'h0000_0007, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{6'h11, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 1'b0, 1};
    vecs[3]  = '{6'h21, 32'hDEAD_BEEF, 32'h0000_0003, 5'd4,  32'h0000_0030, 1'b0, 1'b0, 5};
    vecs[4]  = '{6'h21, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 32};
    vecs[5]  = '{6'h21, 32'h0000_0000, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[6]  = '{6'h00, 32'h0000_0005, 32'h0000_0006, 5'd3,  32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[7]  = '{6'h09, 32'h0000_0002, 32'h0000_0003, 5'd0,  32'h0000_0005, 1'b0, 1'b0, 1};
    vecs[8]  = '{6'h3F, 32'h1111_1111, 32'h2222_2222, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[9]  = '{6'h0A, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[10] = '{6'h21, 32'h0000_0000, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b0, 1'b0, 2};
    vecs[11] = '{6'h21, 32'h0000_0000, 32'h0000_0002, 5'd31, 32'h0000_0000, 1'b1, 1'b0, 32};
    vecs[12] = '{6'h09, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b0, 1};
    vecs[13] = '{6'h11, 32'hAAAA_AAAA, 32'h5555_5555, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[14] = '{6'h01, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.funct = '0;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.shamt = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_zero",   32'(bus.zero), 32'h0);
    chk("rst_err",    32'(bus.err),  32'h0);
    chk("rst_busy",   32'(bus.busy), 32'h0);
    chk("rst_done",   32'(bus.done), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'h0);
      run_op(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].sh, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_done", i),    32'(bus.done), 32'h1);
      chk($sformatf("v%0d_busy", i),    32'(bus.busy), 32'h1);
      chk($sformatf("v%0d_result", i),  bus.result, vecs[i].res);
      chk($sformatf("v%0d_zero", i),    32'(bus.zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_err", i),     32'(bus.err),  32'(vecs[i].e));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_drop", i), 32'(bus.done), 32'h0);
      chk($sformatf("v%0d_hold", i),      bus.result, vecs[i].res);
    end

    // Idle with start low holds the last result for several cycles.
    repeat (4) @(posedge clk);
    #1;
    chk("idle_hold_result", bus.result, 32'h0000_0000);
    chk("idle_hold_zero",   32'(bus.zero), 32'h1);
    chk("idle_hold_err",    32'(bus.err),  32'h1);

    // Start pulses and operand changes during SHIFT are ignored.
    bus.start = 1'b1; bus.funct = 6'h21; bus.src2 = 32'h3; bus.shamt = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct = 6'h09; bus.src1 = 32'h100; bus.src2 = 32'h200; bus.shamt = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("busy_mid_shift", 32'(bus.busy), 32'h1);
    chk("done_mid_shift", 32'(bus.done), 32'h0);
    @(posedge clk); #1;
    chk("busy_start_done",   32'(bus.done), 32'h1);
    chk("busy_start_result", bus.result, 32'h0000_0030);
    @(posedge clk); #1;
    chk("busy_start_no_extra", 32'(bus.done), 32'h0);
    @(posedge clk); #1;
    chk("busy_start_no_extra2", 32'(bus.done), 32'h0);

    // Start held through DONE is only taken in the following IDLE cycle.
    bus.start = 1'b1; bus.funct = 6'h09; bus.src1 = 32'h1; bus.src2 = 32'h1;
    @(posedge clk); #1;
    chk("held_first_done",   32'(bus.done), 32'h1);
    chk("held_first_result", bus.result, 32'h2);
    bus.src1 = 32'h4;
    @(posedge clk); #1;
    chk("held_gap_done", 32'(bus.done), 32'h0);
    chk("held_gap_busy", 32'(bus.busy), 32'h0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("held_second_done",   32'(bus.done), 32'h1);
    chk("held_second_result", bus.result, 32'h5);
    @(posedge clk); #1;

    // Asynchronous reset during SHIFT cycle 3 of a shamt=10 shift.
    bus.start = 1'b1; bus.funct = 6'h21; bus.src2 = 32'h1; bus.shamt = 5'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    held = bus.result;
    chk("pre_rst_result", held, 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", bus.result, 32'h0);
    chk("async_rst_busy",   32'(bus.busy), 32'h0);
    chk("async_rst_done",   32'(bus.done), 32'h0);
    chk("async_rst_zero",   32'(bus.zero), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    npulse = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) npulse++;
      @(posedge clk); #1;
    end
    chk("rst_abort_no_done", 32'(npulse), 32'h0);
    run_op(6'h09, 32'h2, 32'h3, 5'd0, lat);
    chk("post_rst_latency", 32'(lat), 32'h1);
    chk("post_rst_result",  bus.result, 32'h5);
    chk("post_rst_err",     32'(bus.err), 32'h0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width in bits; all arithmetic is modulo 2^DATA_W.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 funct  input  6  ALU-control code: 6'h09 Addu, 6'h0A Subu, 6'h11 And, 6'h21 SLL; any other value is unsupported.
REQ-006 src1  input  DATA_W  first operand (rs).
REQ-007 src2  input  DATA_W  second operand (rt or sign-extended immediate); for SLL, the value that is shifted.
REQ-008 shamt  input  5  shift amount for SLL; ignored for other codes.
REQ-009 result  output  DATA_W  registered result; holds its value until the next completion.
REQ-010 zero  output  1  registered flag, 1 when the completed result equals 0.
REQ-011 err  output  1  registered flag, 1 when the completed operation had an unsupported funct.
REQ-012 busy  output  1  high in SHIFT and DONE; start is ignored while busy.
REQ-013 done  output  1  one-cycle completion pulse; result, zero and err are valid in that cycle.

Function
REQ-014 The block SHALL implement FSM states IDLE, SHIFT and DONE, and done SHALL equal (state==DONE).
REQ-015 IDLE with start=1 and funct in {09, 0A, 11} SHALL, on that edge, register result = src1+src2, src1-src2 or src1&src2 respectively, set err=0, and go to DONE. Latency is 1 edge.
REQ-016 IDLE with start=1 and funct=21, shamt=0 SHALL register result=src2, err=0, and go to DONE.
REQ-017 IDLE with start=1 and funct=21, shamt=k>0 SHALL load the shift register with src2, load the counter with k, and go to SHIFT.
REQ-018 Each SHIFT edge SHALL shift the register left by 1 with zero fill and decrement the counter.
REQ-019 On the SHIFT edge where the counter equals 1, the block SHALL register result = shift register << 1 and go to DONE. SLL latency is 1+k edges, maximum 32.
REQ-020 IDLE with start=1 and an unsupported funct (including 6'h00) SHALL register result=0, err=1, and go to DONE.
REQ-021 zero SHALL be registered as (next result == 0) on every completion edge, including error completions (zero=1 for err).
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE unconditionally. A start held high during DONE is not accepted until the following IDLE cycle.
REQ-023 IDLE with start=0 SHALL hold all outputs.
REQ-024 Operands, funct and shamt SHALL be captured at the start edge. Input changes during SHIFT SHALL have no effect.
REQ-025 Subu SHALL wrap: 0 - 1 = all ones. Addu SHALL discard carry-out. No overflow indication is produced.

Reset
REQ-026 When rst is asserted, the block SHALL asynchronously force: state=IDLE, result=0, zero=0, err=0, busy=0, done=0, counter=0, shift register=0.
REQ-027 Asserting rst mid-operation (in SHIFT or DONE) SHALL abort the operation with no done pulse after release.
REQ-028 The first start sampled after rst deasserts SHALL be accepted normally.

Verification
REQ-029 Addu: src1=32'hFFFF_FFFF, src2=1, start one cycle -> done one edge later, result=0, zero=1, err=0, busy high only during the done cycle.
REQ-030 Subu/And: Subu 5-7 -> result=32'hFFFF_FFFE, zero=0; And 32'hF0F0_F0F0 & 32'h0FF0_0FF0 -> result=32'h00F0_00F0.
REQ-031 SLL: src2=32'h0000_0003, shamt=4 -> done on the 5th edge after start, result=32'h0000_0030. shamt=31, src2=1 -> done on edge 32, result=32'h8000_0000. shamt=0 -> done on edge 1, result=src2.
REQ-032 Error: funct=6'h00 or 6'h3F -> done on edge 1, result=0, err=1, zero=1. A following valid Addu clears err.
REQ-033 Busy/reset: start pulses during SHIFT are ignored and the result is unchanged. rst asserted at SHIFT cycle 3 of shamt=10 -> outputs 0 immediately, no done, and the next Addu 2+3 gives 5.
